// File: rtl/serial_tx_if.sv
// Word handshake between an upstream producer and the serial transmitter.
// The producer drives tx_data/tx_valid; the transmitter answers with tx_ready.
interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter for an idle-high single-wire line.
// Frame: start bit (0), DATA_W data bits LSB first, stop bit (1); each bit is
// held for CLKS_PER_BIT cycles. tx_out is driven straight from a flop.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  serial_tx_if.slave     tx,
  output logic           tx_out,
  output logic           busy
);

  // Counter widths collapse to one bit when the natural width would be zero.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cyc_cnt, cyc_cnt_d;
  logic [BW-1:0]     bit_idx, bit_idx_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic              tx_out_q, tx_out_d;

  logic bit_done;
  logic accept;

  // The current bit has been on the line for its full CLKS_PER_BIT cycles.
  assign bit_done = (cyc_cnt == CYC_LAST);
  assign accept   = tx.tx_valid && (state == ST_IDLE);

  // State register; reset abandons any frame in progress.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking assignments here would create order-dependent
  // simulation and mismatch synthesis.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next-state logic: walk START -> DATA (DATA_W bits) -> STOP -> IDLE.
  // NOTE: the default assignment first means every path assigns state_d, so
  // no latch is inferred even when a case branch leaves it unchanged.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:  if (tx.tx_valid) state_d = ST_START;
      ST_START: if (bit_done) state_d = ST_DATA;
      ST_DATA:  if (bit_done && (bit_idx == BIT_LAST)) state_d = ST_STOP;
      ST_STOP:  if (bit_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and line value for the next cycle, derived from the next state so
  // the line changes in the same edge that changes state.
  always_comb begin
    cyc_cnt_d = cyc_cnt;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    unique case (state)
      ST_IDLE: begin
        cyc_cnt_d = '0;
        bit_idx_d = '0;
        if (accept) shreg_d = tx.tx_data;
      end
      ST_START, ST_STOP: begin
        cyc_cnt_d = bit_done ? '0 : cyc_cnt + 1'b1;
        bit_idx_d = '0;
      end
      ST_DATA: begin
        cyc_cnt_d = bit_done ? '0 : cyc_cnt + 1'b1;
        if (bit_done) begin
          shreg_d   = shreg >> 1;
          bit_idx_d = (bit_idx == BIT_LAST) ? '0 : bit_idx + 1'b1;
        end
      end
      default: begin
        cyc_cnt_d = '0;
        bit_idx_d = '0;
      end
    endcase

    unique case (state_d)
      ST_START: tx_out_d = 1'b0;
      ST_DATA:  tx_out_d = shreg_d[0];
      default:  tx_out_d = 1'b1;
    endcase
  end

  // Counters, shift register and the line flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx_out_q <= 1'b1;
    end else begin
      cyc_cnt  <= cyc_cnt_d;
      bit_idx  <= bit_idx_d;
      shreg    <= shreg_d;
      tx_out_q <= tx_out_d;
    end
  end

  assign tx.tx_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign tx_out      = tx_out_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: one instance with CLKS_PER_BIT=4 and one with
// CLKS_PER_BIT=1. The driver pushes each accepted word with its expected
// start cycle; a negedge monitor pops it when the line drops and compares
// every frame cycle against the frame format.
module tb_serial_tx;

  localparam int DW = 8;

  typedef struct {
    logic [DW-1:0] data;
    int            start_cyc;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  serial_tx_if #(.DATA_W(DW)) if0 ();
  serial_tx_if #(.DATA_W(DW)) if1 ();
  logic tx_out0, busy0, tx_out1, busy1;

  serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(4)) dut0 (
    .clk(clk), .rst(rst), .tx(if0), .tx_out(tx_out0), .busy(busy0)
  );
  serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .tx(if1), .tx_out(tx_out1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  item_t exp_q [2][$];
  int    last_start [2];
  bit    in_frame [2];
  int    pos [2];
  item_t cur [2];
  int    n_checks = 0;
  int    n_fail = 0;

  function automatic int cpb_of(input int inst);
    return (inst == 0) ? 4 : 1;
  endfunction

  function automatic int frame_len(input int inst);
    return (DW + 2) * cpb_of(inst);
  endfunction

  // Line value at cycle p of a frame: start bit, data LSB first, stop bit.
  function automatic logic exp_bit(input logic [DW-1:0] d, input int p, input int cpb);
    int k;
    k = p / cpb;
    if (k == 0) return 1'b0;
    if (k <= DW) return d[k-1];
    return 1'b1;
  endfunction

  function automatic logic get_ready(input int inst);
    return (inst == 0) ? if0.tx_ready : if1.tx_ready;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: the only process that compares.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic o, r, b;
      o = (i == 0) ? tx_out0 : tx_out1;
      b = (i == 0) ? busy0 : busy1;
      r = get_ready(i);
      if (rst) begin
        check($sformatf("reset_state%0d {out,ready,busy}", i), {29'd0, o, r, b}, 32'b110);
        in_frame[i] = 1'b0;
      end else begin
        if (!in_frame[i] && o == 1'b0) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("unexpected_start%0d queue_size", i), exp_q[i].size(), 1);
          end else begin
            cur[i] = exp_q[i].pop_front();
            check($sformatf("start_cycle%0d", i), cyc, cur[i].start_cyc);
            in_frame[i] = 1'b1;
            pos[i] = 0;
          end
        end
        if (in_frame[i]) begin
          check($sformatf("frame%0d data=%0h pos=%0d {out,busy,ready}", i, cur[i].data, pos[i]),
                {29'd0, o, b, r},
                {29'd0, exp_bit(cur[i].data, pos[i], cpb_of(i)), 1'b1, 1'b0});
          pos[i]++;
          if (pos[i] == frame_len(i)) in_frame[i] = 1'b0;
        end else begin
          check($sformatf("idle%0d {out,ready,busy}", i), {29'd0, o, r, b}, 32'b110);
        end
      end
    end
  end

  task automatic set_in(input int inst, input logic [DW-1:0] d, input logic v);
    if (inst == 0) begin if0.tx_data = d; if0.tx_valid = v; end
    else begin if1.tx_data = d; if1.tx_valid = v; end
  endtask

  task automatic set_valid(input int inst, input logic v);
    if (inst == 0) if0.tx_valid = v;
    else if1.tx_valid = v;
  endtask

  // Called just after a negedge. Presents d, waits for ready, records the
  // expected start cycle, and returns at the negedge after the accept edge.
  task automatic send(input int inst, input logic [DW-1:0] d, input bit hold, input bit b2b);
    int guard;
    int start;
    set_in(inst, d, 1'b1);
    guard = 0;
    while (!get_ready(inst)) begin
      @(negedge clk);
      guard++;
      if (guard > 1000) begin
        $display("FAIL send_timeout%0d: tx_ready stayed %0d for %0d cycles, required 1", inst, get_ready(inst), guard);
        $fatal(1, "handshake timeout");
      end
    end
    start = b2b ? last_start[inst] + frame_len(inst) + 1 : cyc + 1;
    last_start[inst] = start;
    exp_q[inst].push_back('{data: d, start_cyc: start});
    @(negedge clk);
    if (!hold) set_valid(inst, 1'b0);
  endtask

  task automatic wait_idle(input int inst);
    int guard;
    guard = 0;
    while (exp_q[inst].size() != 0 || in_frame[inst] || !get_ready(inst)) begin
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        $display("FAIL idle_timeout%0d: %0d frames pending, required 0", inst, exp_q[inst].size());
        $fatal(1, "drain timeout");
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 8'hFF, 1'b1);
    set_in(1, 8'hFF, 1'b1);
    repeat (5) @(negedge clk);
    set_valid(0, 1'b0);
    set_valid(1, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame.
    send(0, 8'hA5, 1'b0, 1'b0);
    wait_idle(0);

    // Back-to-back with tx_valid held across both frames.
    send(0, 8'h00, 1'b1, 1'b0);
    send(0, 8'hFF, 1'b0, 1'b1);
    wait_idle(0);

    // Input changes during a frame must not disturb it or cause an accept.
    send(0, 8'h3C, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if0.tx_data  = 8'hC3;
      if0.tx_valid = k[0];
    end
    if0.tx_valid = 1'b0;
    wait_idle(0);

    // Asynchronous reset during data bit 3, then a fresh frame.
    send(0, 8'h0F, 1'b0, 1'b0);
    repeat (17) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    send(0, 8'h81, 1'b0, 1'b0);
    wait_idle(0);

    // One cycle per bit.
    send(1, 8'h01, 1'b0, 1'b0);
    wait_idle(1);

    // Random words on both instances with random gaps.
    for (int n = 0; n < 16; n++) begin
      int inst;
      inst = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(inst, DW'($urandom), 1'b0, 1'b0);
    end
    wait_idle(0);
    wait_idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parallel-to-serial transmitter that drives a single-wire, idle-high serial line.
- Frame format: one start bit (0), DATA_W data bits LSB first, one stop bit (1).
- Each bit is held for CLKS_PER_BIT clock cycles.
- Sits at the sending end of the team's serial link and feeds a downstream sampling/capture stage. Upstream logic hands it words through a valid/ready handshake.

Parameters:
- DATA_W, 8, width of the data word per frame; must be >= 1.
- CLKS_PER_BIT, 4, clock cycles each serial bit is held; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_data  input  DATA_W  word to transmit; sampled only on the accept cycle.
- tx_valid  input  1  upstream has a word on tx_data.
- tx_ready  output  1  block can accept a word this cycle.
- tx_out  output  1  serial line; idles at 1.
- busy  output  1  frame in progress (START, DATA or STOP state).

Behaviour:
- Reset (async, immediate, also mid-frame):
  - state=IDLE, tx_out=1, tx_ready=1, busy=0.
  - Bit counter, cycle counter and shift register clear to 0.
  - The frame in progress is abandoned; no partial frame resumes after rst deasserts.
- States are IDLE, START, DATA and STOP. tx_ready = (state==IDLE); busy = !tx_ready. Both are registered-state derived and glitch-free.
- Accept happens on the rising edge where tx_valid && tx_ready:
  - tx_data is latched into the shift register.
  - The next state is START.
  - tx_valid without tx_ready is ignored. Upstream holds tx_valid until it sees ready.
- Latency: tx_out drops to 0 in the cycle immediately after the accept edge.
- START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx_out = shift register bit 0.
  - After CLKS_PER_BIT cycles, shift right by one and increment the bit index.
  - After bit DATA_W-1 completes, go to STOP.
- STOP: tx_out=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Frame length is exactly (DATA_W+2)*CLKS_PER_BIT cycles, from the first cycle of the start bit to the last cycle of the stop bit.
- Back-to-back frames:
  - tx_ready reasserts in the cycle after the last stop-bit cycle.
  - A held tx_valid is accepted at that IDLE cycle, so there is a minimum 1-cycle idle gap (line=1) between frames.
- Changes on tx_data or tx_valid after the accept edge have no effect on the current frame.
- Counter widths:
  - Cycle counter is $clog2(CLKS_PER_BIT) bits, minimum 1 bit; it wraps 0..CLKS_PER_BIT-1.
  - Bit index is $clog2(DATA_W) bits, minimum 1 bit.
  - No counter ever exceeds its terminal value.
- CLKS_PER_BIT=1: every bit lasts exactly one cycle and the counter logic degenerates correctly. The frame is DATA_W+2 cycles.
- tx_out comes directly from a flop, with no combinational path from inputs to tx_out.

Test Plan:
- Reset check: hold rst=1 with tx_valid=1 and tx_data=8'hFF -> tx_out=1, tx_ready=1, busy=0. No frame starts while rst=1.
- Single frame (DATA_W=8, CLKS_PER_BIT=4): send 8'hA5 ->
  - tx_out sequence is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total).
  - tx_out first goes low the cycle after accept.
  - busy is high for exactly 40 cycles; tx_ready returns to 1 on cycle 41.
- Back-to-back: hold tx_valid=1 with 8'h00 then 8'hFF ->
  - Both frames are correct.
  - Exactly one idle cycle (tx_out=1, tx_ready=1) separates the stop bit of frame 1 from the start bit of frame 2.
- Data stability: accept 8'h3C, then drive tx_data=8'hC3 and toggle tx_valid during the frame -> the serialized bits are still those of 8'h3C. No extra accept occurs before the frame ends.
- Reset mid-frame: assert rst asynchronously during data bit 3 of 8'h0F -> tx_out=1 without waiting for a clock edge. After release, the line stays idle until a new tx_valid, and the next frame (8'h81) is complete and correct.
- CLKS_PER_BIT=1, DATA_W=8: send 8'h01 -> the 10-cycle frame is 0,1,0,0,0,0,0,0,0,1, and tx_ready reasserts on cycle 11.
